// File: rtl/mem_wb_writeback_if.sv
// mem_wb_writeback_if: MEM-stage capture, register-file write port and ID-stage bypass signals
interface mem_wb_writeback_if #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5
);
  logic              mem_valid;
  logic              mem_reg_write;
  logic              mem_to_reg;
  logic [REG_AW-1:0] mem_rd;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_read_data;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] WriteData;
  logic [REG_AW-1:0] RD;
  logic              RegWrite;
  logic              wb_valid;
  logic [31:0]       retired_count;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [DATA_W-1:0] id_rdata1;
  logic [DATA_W-1:0] id_rdata2;
  logic [DATA_W-1:0] id_fwd1;
  logic [DATA_W-1:0] id_fwd2;
  modport master (
    output mem_valid, mem_reg_write, mem_to_reg, mem_rd, mem_alu_result, mem_read_data,
           stall, flush, id_rs1, id_rs2, id_rdata1, id_rdata2,
    input  WriteData, RD, RegWrite, wb_valid, retired_count, id_fwd1, id_fwd2
  );
  modport slave (
    input  mem_valid, mem_reg_write, mem_to_reg, mem_rd, mem_alu_result, mem_read_data,
           stall, flush, id_rs1, id_rs2, id_rdata1, id_rdata2,
    output WriteData, RD, RegWrite, wb_valid, retired_count, id_fwd1, id_fwd2
  );
endinterface

// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: MEM/WB pipeline register, register-file write driver and retire counter.
// Define WB_BYPASS_EN to forward the same-cycle write to the ID-stage read operands.
module mem_wb_writeback #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5
) (
  input logic clk,
  input logic reset,
  mem_wb_writeback_if.slave bus
);
  logic              r_valid;
  logic              r_reg_write;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_data;
  logic [31:0]       r_count;
  logic [DATA_W-1:0] w_data;
  logic              w_retire;
  logic              w_reg_write;
  assign w_data = bus.mem_to_reg ? bus.mem_read_data : bus.mem_alu_result;
  // the occupant leaves on any non-stalled edge, and always on flush
  assign w_retire = r_valid & (~bus.stall | bus.flush);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_data      <= '0;
    end else if (bus.flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_data      <= '0;
    end else if (!bus.stall) begin
      r_valid     <= bus.mem_valid;
      r_reg_write <= bus.mem_reg_write;
      r_rd        <= bus.mem_rd;
      r_data      <= w_data;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_count <= '0;
    else if (w_retire) r_count <= r_count + 32'd1;
  end
  assign w_reg_write       = r_valid & r_reg_write & (r_rd != '0);
  assign bus.WriteData     = r_data;
  assign bus.RD            = r_rd;
  assign bus.RegWrite      = w_reg_write;
  assign bus.wb_valid      = r_valid;
  assign bus.retired_count = r_count;
`ifdef WB_BYPASS_EN
  assign bus.id_fwd1 = (w_reg_write && r_rd == bus.id_rs1) ? r_data : bus.id_rdata1;
  assign bus.id_fwd2 = (w_reg_write && r_rd == bus.id_rs2) ? r_data : bus.id_rdata2;
`else
  logic w_unused;
  assign w_unused    = ^{bus.id_rs1, bus.id_rs2};
  assign bus.id_fwd1 = bus.id_rdata1;
  assign bus.id_fwd2 = bus.id_rdata2;
`endif
endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb_mem_wb_writeback: directed checks of capture, x0 suppression, stall/flush, reset, wrap and bypass
module tb_mem_wb_writeback;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  mem_wb_writeback_if #(.DATA_W(64), .REG_AW(5)) bus ();
  mem_wb_writeback #(.DATA_W(64), .REG_AW(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                       input logic [63:0] alu, input logic [63:0] rdat);
    bus.mem_valid = v;
    bus.mem_reg_write = rw;
    bus.mem_to_reg = m2r;
    bus.mem_rd = rd;
    bus.mem_alu_result = alu;
    bus.mem_read_data = rdat;
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk_out(input string tag, input logic we, input logic [4:0] rd, input logic [63:0] wd,
                         input logic v, input logic [31:0] cnt);
    chk({tag, ".RegWrite"}, {63'd0, bus.RegWrite}, {63'd0, we});
    chk({tag, ".RD"}, {59'd0, bus.RD}, {59'd0, rd});
    chk({tag, ".WriteData"}, bus.WriteData, wd);
    chk({tag, ".wb_valid"}, {63'd0, bus.wb_valid}, {63'd0, v});
    chk({tag, ".count"}, {32'd0, bus.retired_count}, {32'd0, cnt});
  endtask
  initial begin
    drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.id_rs1 = 5'd0;
    bus.id_rs2 = 5'd0;
    bus.id_rdata1 = 64'd0;
    bus.id_rdata2 = 64'd0;
    @(negedge clk);
    @(negedge clk);
    chk_out("reset", 1'b0, 5'd0, 64'd0, 1'b0, 32'd0);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 5'd5, 64'h1234, 64'h9999);
    step();
    chk_out("alu", 1'b1, 5'd5, 64'h1234, 1'b1, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 5'd0, 64'h1, 64'hDEAD_BEEF);
    step();
    chk_out("load_x0", 1'b0, 5'd0, 64'hDEAD_BEEF, 1'b1, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 5'd9, 64'hAAAA, 64'h0);
    step();
    chk_out("alu9", 1'b1, 5'd9, 64'hAAAA, 1'b1, 32'd2);
    bus.stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 5'd10, 64'hBBBB, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("stall", 1'b1, 5'd9, 64'hAAAA, 1'b1, 32'd2);
    end
    bus.flush = 1'b1;
    step();
    chk_out("flush_stall", 1'b0, 5'd0, 64'd0, 1'b0, 32'd3);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 5'd4, 64'h44, 64'h0);
    step();
    chk_out("invalid_rw", 1'b0, 5'd4, 64'h44, 1'b0, 32'd3);
    step();
    chk_out("invalid_rw2", 1'b0, 5'd4, 64'h44, 1'b0, 32'd3);
    drive(1'b1, 1'b1, 1'b0, 5'd7, 64'h55, 64'h0);
    step();
    bus.id_rs1 = 5'd7;
    bus.id_rdata1 = 64'h08;
    bus.id_rs2 = 5'd3;
    bus.id_rdata2 = 64'h33;
    #1;
`ifdef WB_BYPASS_EN
    chk("fwd1", bus.id_fwd1, 64'h55);
`else
    chk("fwd1", bus.id_fwd1, 64'h08);
`endif
    chk("fwd2", bus.id_fwd2, 64'h33);
    chk_out("bypass_state", 1'b1, 5'd7, 64'h55, 1'b1, 32'd3);
    bus.stall = 1'b1;
    step();
    #1;
    reset = 1'b0;
    #1;
    chk_out("async_reset", 1'b0, 5'd0, 64'd0, 1'b0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bus.stall = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd6, 64'h77, 64'h0);
    step();
    chk_out("post_reset", 1'b1, 5'd6, 64'h77, 1'b1, 32'd0);
    force dut.r_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_count;
    #1;
    chk("preload", {32'd0, bus.retired_count}, 64'hFFFF_FFFF);
    drive(1'b1, 1'b1, 1'b0, 5'd1, 64'h11, 64'h0);
    step();
    chk_out("wrap", 1'b1, 5'd1, 64'h11, 1'b1, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
